// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit frame controllers.
//   - uart_state_e : Gray-coded frame FSM states (the TX FSM uses the same set)
//   - PAR_EVEN/PAR_ODD : encodings of the PAR_TYP configuration bit
//   - PRESCALE_8/16/32 : the supported oversampling ratios
//   - expected_parity(): parity bit a transmitter would append to a word
package uart_pkg;

  // Adjacent states differ in one bit along the normal frame path.
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b011,
    PARITY = 3'b010,
    STOP   = 3'b110
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // data_xor is the XOR-reduction of the data bits.
  function automatic logic expected_parity(input logic data_xor, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point majority sampler for one oversampled UART bit period.
// Ports:
//   CLK, RST     : clock, asynchronous active-low reset
//   line         : synchronized serial line
//   edge_cnt     : position inside the current bit period (0..P-1)
//   prescale     : oversampling ratio P for the current frame
//   sampled_bit  : 2-of-3 majority of the samples at P/2-1, P/2, P/2+1
//   decision     : high on edge_cnt == P/2+2, when sampled_bit is final
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  line,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit,
  output logic                  decision
);

  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] pos_a;
  logic [PRESCALE_W-1:0] pos_b;
  logic [PRESCALE_W-1:0] pos_c;
  logic [PRESCALE_W-1:0] pos_dec;
  logic [2:0]            samples;

  always_comb begin
    half    = prescale >> 1;
    pos_a   = half - PRESCALE_W'(1);
    pos_b   = half;
    pos_c   = half + PRESCALE_W'(1);
    pos_dec = half + PRESCALE_W'(2);
  end

  // Samples reset to the idle line level so a stray vote can never read low.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samples <= 3'b111;
    end else begin
      if (edge_cnt == pos_a) samples[0] <= line;
      if (edge_cnt == pos_b) samples[1] <= line;
      if (edge_cnt == pos_c) samples[2] <= line;
    end
  end

  assign sampled_bit = (samples[0] & samples[1]) |
                       (samples[0] & samples[2]) |
                       (samples[1] & samples[2]);
  assign decision    = (edge_cnt == pos_dec);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive frame controller: start, DATA_WIDTH data bits LSB first,
// optional parity, stop. Runs on a Prescale x baud clock.
// Ports:
//   CLK, RST      : oversampling clock, asynchronous active-low reset
//   RX_IN         : serial line, idle high, asynchronous to CLK
//   Prescale      : oversampling ratio (8, 16 or 32), latched per frame
//   PAR_EN        : frame carries a parity bit, latched per frame
//   PAR_TYP       : 0 even, 1 odd parity, latched per frame
//   P_DATA        : last good received word
//   Data_Valid    : one-cycle strobe when P_DATA is updated
//   Parity_Error  : parity mismatch on the current/last frame
//   Stop_Error    : stop bit sampled low on the current/last frame
//   Busy          : frame in progress
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error,
  output logic                  Busy
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  uart_state_e           state;
  uart_state_e           next_state;
  logic                  rx_meta;
  logic                  line;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  sampled_bit;
  logic                  decision;
  logic                  wrap;
  logic                  start_entry;

  // Two-flop synchronizer; resets to the idle-high line level so reset
  // release never looks like a start edge.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1;
      line    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      line    <= rx_meta;
    end
  end

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .line        (line),
    .edge_cnt    (edge_cnt),
    .prescale    (prescale_q),
    .sampled_bit (sampled_bit),
    .decision    (decision)
  );

  assign wrap        = (edge_cnt == prescale_q - PRESCALE_W'(1));
  assign start_entry = (state == IDLE) && !line;
  assign Busy        = (state != IDLE);

  // NOTE: next_state gets its default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!line) next_state = START;
      START: begin
        if (decision && sampled_bit) next_state = IDLE;  // glitch, not a start bit
        else if (wrap)               next_state = DATA;
      end
      DATA:    if (wrap && bit_cnt == LAST_BIT) next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (wrap) next_state = STOP;
      // Leave at the stop decision, half a bit early, so a back-to-back
      // start edge is not missed.
      STOP:    if (decision) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      prescale_q   <= PRESCALE_W'(PRESCALE_8);
      par_en_q     <= 1'b0;
      par_typ_q    <= PAR_EVEN;
      P_DATA       <= '0;
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;

      // Counter is 0 on the first START cycle and after every bit wrap.
      if (state == IDLE || next_state == IDLE || wrap) edge_cnt <= '0;
      else                                             edge_cnt <= edge_cnt + PRESCALE_W'(1);

      if (state != DATA)      bit_cnt <= '0;
      else if (wrap)          bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_CNT_W'(1);

      if (start_entry) begin
        prescale_q   <= Prescale;
        par_en_q     <= PAR_EN;
        par_typ_q    <= PAR_TYP;
        Parity_Error <= 1'b0;
        Stop_Error   <= 1'b0;
      end

      if (state == DATA && decision)
        shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};

      if (state == PARITY && decision)
        Parity_Error <= (sampled_bit != expected_parity(^shift_reg, par_typ_q));

      if (state == STOP && decision) begin
        Stop_Error <= !sampled_bit;
        if (sampled_bit && !Parity_Error) begin
          Data_Valid <= 1'b1;
          P_DATA     <= shift_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: the stimulus side pushes the expected
// word and START-to-Data_Valid latency; a negedge monitor pops and compares
// on every Data_Valid.
module tb_uart_rx_frame;
  import uart_pkg::*;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Parity_Error;
  logic       Stop_Error;
  logic       Busy;

  typedef struct {
    logic [7:0] data;
    int         lat;   // 0 = latency not checked
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  logic busy_prev = 1'b0;

  uart_rx_frame #(
    .DATA_WIDTH (8),
    .PRESCALE_W (6)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .Parity_Error (Parity_Error),
    .Stop_Error   (Stop_Error),
    .Busy         (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: cycle 0 is the first negedge with Busy high.
  always @(negedge CLK) begin
    exp_t e;
    cyc++;
    if (Busy && !busy_prev) start_cyc = cyc;
    busy_prev = Busy;
    if (Data_Valid) begin
      if (sb_q.size() == 0) begin
        check("dv_unexpected", 32'(Data_Valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_p_data", 32'(P_DATA), 32'(e.data));
        if (e.lat != 0) check("sb_latency", 32'(cyc - start_cyc), 32'(e.lat));
        check("sb_flags", {30'd0, Parity_Error, Stop_Error}, 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Noise inverts the line for one cycle at bit position P/2+1, which the
  // synchronizer delay places on the edge_cnt = P/2 sample.
  task automatic drive_bit(input logic b, input int p, input bit noise);
    for (int i = 0; i < p; i++) begin
      RX_IN = (noise && i == p / 2 + 1) ? ~b : b;
      @(negedge CLK);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_en, input logic par_bit,
                            input logic stop_bit, input int p, input bit noise);
    drive_bit(1'b0, p, noise);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p, noise);
    if (par_en) drive_bit(par_bit, p, noise);
    drive_bit(stop_bit, p, noise);
    RX_IN = 1'b1;
  endtask

  task automatic push(input logic [7:0] d, input int lat);
    exp_t e;
    e.data = d;
    e.lat  = lat;
    sb_q.push_back(e);
  endtask

  initial begin
    bit saw_busy;
    RST      = 1'b0;
    RX_IN    = 1'b1;
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = PAR_EVEN;
    idle(3);
    check("rst_p_data", 32'(P_DATA), 32'd0);
    check("rst_dv", 32'(Data_Valid), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_perr", 32'(Parity_Error), 32'd0);
    check("rst_serr", 32'(Stop_Error), 32'd0);
    RST = 1'b1;
    idle(5);

    // P=8, no parity: (10-1)*8 + 4 + 3 = 79
    push(8'hA5, 79);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8, 1'b0);
    idle(10);
    check("t1_perr", 32'(Parity_Error), 32'd0);
    check("t1_serr", 32'(Stop_Error), 32'd0);
    check("t1_busy", 32'(Busy), 32'd0);

    // P=16, even parity, 0x3C has four ones -> parity bit 0; (11-1)*16+8+3 = 171
    Prescale = 6'd16;
    PAR_EN   = 1'b1;
    PAR_TYP  = PAR_EVEN;
    push(8'h3C, 171);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16, 1'b0);
    idle(12);
    check("t2a_perr", 32'(Parity_Error), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16, 1'b0);
    idle(12);
    check("t2b_perr", 32'(Parity_Error), 32'd1);
    check("t2b_serr", 32'(Stop_Error), 32'd0);
    check("t2b_p_data", 32'(P_DATA), 32'h3C);

    // P=8, odd parity, 0x01 -> parity bit 0 is correct; stop bit low
    Prescale = 6'd8;
    PAR_TYP  = PAR_ODD;
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 8, 1'b0);
    idle(4);
    check("t3_serr", 32'(Stop_Error), 32'd1);
    check("t3_perr", 32'(Parity_Error), 32'd0);
    check("t3_busy", 32'(Busy), 32'd0);
    check("t3_p_data", 32'(P_DATA), 32'h3C);

    // Start glitch at P=16: two low cycles, then high
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    PAR_TYP  = PAR_EVEN;
    RX_IN    = 1'b0;
    idle(2);
    RX_IN    = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 10 && !saw_busy; i++) begin
      @(negedge CLK);
      if (Busy) saw_busy = 1'b1;
    end
    check("t4_busy_pulse", 32'(saw_busy), 32'd1);
    idle(30);
    check("t4_busy_end", 32'(Busy), 32'd0);
    check("t4_serr", 32'(Stop_Error), 32'd0);
    check("t4_perr", 32'(Parity_Error), 32'd0);

    // Back-to-back at P=32 with one-cycle noise in every bit: 9*32+16+3 = 307
    Prescale = 6'd32;
    push(8'h55, 307);
    push(8'hAA, 307);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 32, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 32, 1'b1);
    idle(40);
    check("t5_p_data", 32'(P_DATA), 32'hAA);

    // Reset in the middle of DATA, then a clean frame
    Prescale = 6'd8;
    drive_bit(1'b0, 8, 1'b0);
    drive_bit(1'b1, 8, 1'b0);
    drive_bit(1'b1, 8, 1'b0);
    drive_bit(1'b0, 8, 1'b0);
    RST = 1'b0;
    #1;
    check("t6_rst_p_data", 32'(P_DATA), 32'd0);
    check("t6_rst_busy", 32'(Busy), 32'd0);
    check("t6_rst_dv", 32'(Data_Valid), 32'd0);
    check("t6_rst_flags", {30'd0, Parity_Error, Stop_Error}, 32'd0);
    RX_IN = 1'b1;
    idle(2);
    RST = 1'b1;
    idle(5);
    push(8'h0F, 79);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 8, 1'b0);
    idle(10);
    check("t6_p_data", 32'(P_DATA), 32'h0F);

    check("sb_missing_dv", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
UART receive-side frame controller. It is the counterpart of the serial transmit FSM and recovers frames of the form start, DATA_WIDTH data bits LSB-first, optional parity, and stop.
- Runs on an oversampling clock at Prescale x baud.
- Majority-votes each bit and deserializes the data.
- Checks parity and stop, then presents a parallel word with a single-cycle valid strobe to the system/register side.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the Prescale input and of the edge counter.

Ports:
- CLK  in  1  oversampling clock, Prescale x baud rate.
- RST  in  1  asynchronous, active-low reset.
- RX_IN  in  1  serial line; idle high; asynchronous to CLK.
- Prescale  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_TYP  in  1  0 = even, 1 = odd.
- P_DATA  out  DATA_WIDTH  received word.
- Data_Valid  out  1  one-cycle strobe; P_DATA is good.
- Parity_Error  out  1  parity mismatch on the current/last frame.
- Stop_Error  out  1  stop bit sampled low on the current/last frame.
- Busy  out  1  high while a frame is in progress (not IDLE).

Behaviour:
- Reset (RST low, any time including mid-frame): clears state to IDLE, all counters, the synchronizer (to 1), and every output to 0 (P_DATA = 0). There is no recovery of a partial frame.
- Synchronization: RX_IN passes through a 2-flop synchronizer. All references to "line" below mean the synchronized value.
- Configuration latch: Prescale, PAR_EN and PAR_TYP are latched on START entry and held for the rest of the frame. Behaviour for Prescale values other than 8, 16 or 32 is undefined.
- States use Gray encoding: IDLE, START, DATA, PARITY, STOP.
- Edge counter: edge_cnt runs 0..P-1 within each bit period (P = latched Prescale). It is 0 on the first cycle in START and wraps at P-1 to advance to the next bit. The bit counter counts 0..DATA_WIDTH-1 in DATA.
- Sampling: take three samples at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority, valid at the decision point edge_cnt = P/2+2.
- IDLE: line low -> START on the next cycle. Otherwise stay in IDLE.
- START: at the decision point, bit = 1 -> IDLE (glitch rejection; no flags change). At wrap -> DATA.
- DATA: at each decision point, shift the bit into the shift register, LSB first. On wrap of the last bit -> PARITY if PAR_EN, else STOP.
- PARITY: at the decision point, expected parity is XOR(data) for even and XNOR(data) for odd. Parity_Error = (sample != expected). At wrap -> STOP.
- STOP: at the decision point, Stop_Error = (sample == 0), then -> IDLE immediately. This gives half a bit of margin for a back-to-back start edge.
- Data_Valid:
  - Asserted for exactly 1 cycle, the cycle after the stop decision, and only if there is no parity or stop error.
  - P_DATA updates in the same cycle as Data_Valid and holds until the next valid frame.
  - On error, P_DATA keeps its old value.
- Error flags: both flags clear on START entry. Otherwise they hold until then.
- Latency: with START entry as cycle 0 and N = frame bits (10 without parity, 11 with), Data_Valid is high at cycle (N-1)*P + P/2 + 3.
- Busy: 0 in IDLE, 1 in all other states.
- Line low at the STOP decision point: Stop_Error is set, the FSM goes to IDLE, and the still-low line starts a new frame (break/garbage tolerance).

Decomposition:
- Shared package uart_pkg holds:
  - the Gray state encodings, common with the TX FSM;
  - the PAR_EVEN/PAR_ODD constants;
  - the legal prescale constants.
- One sub-module, uart_rx_sampler:
  - inputs: line, edge_cnt, P;
  - behaviour: 3-sample majority vote;
  - outputs: the sampled bit and a decision strobe.

Test Plan:
- Prescale=8, PAR_EN=0, frame with data 0xA5 -> P_DATA=0xA5, Data_Valid high exactly at cycle 79 after START entry, both error flags 0.
- Prescale=16, PAR_EN=1, PAR_TYP=0, data 0x3C with parity 0 -> P_DATA=0x3C, Data_Valid at cycle 171, Parity_Error=0. The same frame with parity 1 -> Parity_Error=1, no Data_Valid, P_DATA unchanged.
- Prescale=8, odd parity, data 0x01 with parity 0, stop bit driven 0 -> Stop_Error=1, Parity_Error=0, no Data_Valid. Busy goes to 0 after the stop decision.
- Start glitch: line low for 2 cycles then high, Prescale=16 -> FSM returns to IDLE, Busy pulses then returns to 0, no flags, no Data_Valid.
- Back-to-back frames 0x55 then 0xAA, Prescale=32, no idle gap, each bit with one-cycle noise injected at edge_cnt=P/2 -> two Data_Valid pulses with 0x55 then 0xAA.
- RST asserted mid-DATA -> all outputs 0 and state IDLE immediately. The following clean frame 0x0F is received correctly.
